axis_scale_multiplier: RTL and testbench

- Streaming fixed-point multiplier directly downstream of the AXI-Lite scale register block; consumes its `scale_reg` output.
- Multiplies every sample of an AXI-Stream by the programmed scale, then rounds and range-limits the result.
- Feeds the KAN datapath.
- The scale is snapshotted per packet, so software writes made mid-packet never split a packet across two scale values.

---
 rtl/axis_scale_multiplier.sv | 146 ++++++++++++++
 tb/tb_axis_scale_multiplier.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_scale_multiplier.sv
// Purpose : AXI-Stream fixed-point scaler; the scale is snapshotted per packet, then rounded and range-limited.
// Latency : 3 cycles (S1 capture, S2 multiply, S3 round/limit); one beat per cycle.
// Backpr. : single global enable (~m_axis_tvalid | m_axis_tready) stalls all stages; s_axis_tready = enable.
// Option  : define AXIS_SCALE_SAT_EN to saturate out-of-range results; otherwise they wrap.
module axis_scale_multiplier #(
  parameter int DATA_WIDTH  = 16,
  parameter int SCALE_WIDTH = 16,
  parameter int SCALE_FRAC  = 8
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [SCALE_WIDTH-1:0] scale_reg,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   ovf_pulse,
  output logic                   busy
);

  localparam int PW = DATA_WIDTH + SCALE_WIDTH;

  logic                          en;
  logic                          accept;
  logic                          in_packet;
  logic signed [SCALE_WIDTH-1:0] scale_q;
  logic signed [SCALE_WIDTH-1:0] scale_sel;

  logic                          v1, l1;
  logic signed [DATA_WIDTH-1:0]  d1;
  logic signed [SCALE_WIDTH-1:0] sc1;

  logic                          v2, l2;
  logic signed [PW-1:0]          prod2;
  logic signed [PW-1:0]          d1_ext, sc1_ext, prod_c;

  logic signed [PW:0]            r_c;
  logic                          ovf_c;
  logic [DATA_WIDTH-1:0]         lim_c;
  logic                          ovf3;

  assign en            = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = en;
  assign accept        = s_axis_tvalid & en;
  assign busy          = v1 | v2 | m_axis_tvalid | in_packet;

  // First beat of a packet sees the live register; later beats see the snapshot.
  assign scale_sel = in_packet ? scale_q : $signed(scale_reg);

  // Track packet boundaries and take the per-packet scale snapshot.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      in_packet <= 1'b0;
      scale_q   <= '0;
    end else if (accept) begin
      in_packet <= ~s_axis_tlast;
      if (!in_packet) scale_q <= $signed(scale_reg);
    end
  end

  // S1: capture the sample together with the scale it must use.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      v1  <= 1'b0;
      l1  <= 1'b0;
      d1  <= '0;
      sc1 <= '0;
    end else if (en) begin
      v1  <= s_axis_tvalid;
      l1  <= s_axis_tlast;
      d1  <= $signed(s_axis_tdata);
      sc1 <= scale_sel;
    end
  end

  // Operands sign-extended to the full product width before multiplying.
  assign d1_ext  = $signed({{SCALE_WIDTH{d1[DATA_WIDTH-1]}}, d1});
  assign sc1_ext = $signed({{DATA_WIDTH{sc1[SCALE_WIDTH-1]}}, sc1});
  assign prod_c  = d1_ext * sc1_ext;

  // S2: register the full-precision product.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      v2    <= 1'b0;
      l2    <= 1'b0;
      prod2 <= '0;
    end else if (en) begin
      v2    <= v1;
      l2    <= l1;
      prod2 <= prod_c;
    end
  end

  // Round half toward +inf; one guard bit keeps the rounding add from overflowing.
  generate
    if (SCALE_FRAC > 0) begin : g_round
      localparam logic signed [PW:0] RND = {{PW{1'b0}}, 1'b1} << (SCALE_FRAC - 1);
      logic signed [PW:0] sum_c;
      // Add the half-LSB and arithmetic-shift away the fraction.
      always_comb begin
        sum_c = {prod2[PW-1], prod2} + RND;
        r_c   = sum_c >>> SCALE_FRAC;
      end
    end else begin : g_noround
      // Integer scale: the product is already the result.
      always_comb begin
        r_c = {prod2[PW-1], prod2};
      end
    end
  endgenerate

  // In range only if every bit above the output sign bit matches it.
  assign ovf_c = ~((&r_c[PW:DATA_WIDTH-1]) | ~(|r_c[PW:DATA_WIDTH-1]));

`ifdef AXIS_SCALE_SAT_EN
  assign lim_c = ovf_c ? {r_c[PW], {(DATA_WIDTH-1){~r_c[PW]}}} : r_c[DATA_WIDTH-1:0];
`else
  assign lim_c = r_c[DATA_WIDTH-1:0];
`endif

  // S3: output register; holds while the downstream stalls.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      ovf3          <= 1'b0;
    end else if (en) begin
      m_axis_tvalid <= v2;
      m_axis_tlast  <= l2;
      m_axis_tdata  <= lim_c;
      ovf3          <= ovf_c;
    end
  end

  // Flag an out-of-range beat in the cycle after it leaves on m_axis.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ovf_pulse <= 1'b0;
    else                ovf_pulse <= m_axis_tvalid & m_axis_tready & ovf3;
  end

endmodule

// File: tb/tb_axis_scale_multiplier.sv
// Bench for axis_scale_multiplier: directed packets checked against a reference model.
// The model works from integer arithmetic on each accepted beat; outputs are compared every cycle.
// A few hand-computed literals pin the model's results.
module tb_axis_scale_multiplier;

  localparam int DW = 16;
  localparam int SW = 16;
  localparam int SF = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] scale_reg;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic          ovf_pulse, busy;

  axis_scale_multiplier #(.DATA_WIDTH(DW), .SCALE_WIDTH(SW), .SCALE_FRAC(SF)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .scale_reg(scale_reg),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .ovf_pulse(ovf_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    logic          o;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] out_log[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ovf_seen = 0;
  int            n_in = 0;
  int            n_out = 0;
  bit            strict = 1'b1;
  bit            pend_ovf = 1'b0;
  bit            hold = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  bit            tb_in_pkt = 1'b0;
  int            tb_pkt_scale = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact product, floor((p + half) / 2^SF), then range limit.
  function automatic logic [DW:0] model(input int d, input int s);
    longint p, q, r, half, div, maxv, minv;
    logic [DW-1:0] y;
    logic o;
    half = 64'sd1 <<< (SF - 1);
    div  = 64'sd1 <<< SF;
    maxv = (64'sd1 <<< (DW - 1)) - 1;
    minv = -(64'sd1 <<< (DW - 1));
    p = longint'(d) * longint'(s);
    q = p + half;
    if (q >= 0) r = q / div;
    else        r = -((-q + div - 1) / div);
    o = (r > maxv) || (r < minv);
`ifdef AXIS_SCALE_SAT_EN
    if (r > maxv)      y = 16'h7FFF;
    else if (r < minv) y = 16'h8000;
    else               y = r[DW-1:0];
`else
    y = r[DW-1:0];
`endif
    return {o, y};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare and input observation, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_ovf = 1'b0;
      hold     = 1'b0;
    end else begin
      exp_t e;
      logic [DW:0] m;
      chk("s_tready_rule", s_tready, !m_tvalid || m_tready);
      chk("ovf_pulse", ovf_pulse, pend_ovf);
      if (ovf_pulse) ovf_seen++;
      pend_ovf = 1'b0;
      if (hold) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, hold_d);
        chk("hold_last", m_tlast, hold_l);
      end
      hold   = m_tvalid && !m_tready;
      hold_d = m_tdata;
      hold_l = m_tlast;
      if (m_tvalid && m_tready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat: got data %0h with no beat expected", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_last", m_tlast, e.l);
          if (strict) chk("latency", cyc - e.cyc, 3);
          pend_ovf = e.o;
        end
        out_log.push_back(m_tdata);
      end
      if (s_tvalid && s_tready) begin
        n_in++;
        if (!tb_in_pkt) tb_pkt_scale = int'($signed(scale_reg));
        m = model(int'($signed(s_tdata)), tb_pkt_scale);
        tb_in_pkt = !s_tlast;
        e.d = m[DW-1:0];
        e.o = m[DW];
        e.l = s_tlast;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  // Present one beat and hold it until it is accepted; returns at posedge + 1.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int  n;
    bit  ok;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, o0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    m_tready = 1'b1; scale_reg = 16'h0100;
    #12;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_ovf", ovf_pulse, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Unity gain
    b = out_log.size();
    send(16'd1234, 1'b0); send(16'hFFFB, 1'b0); send(16'd0, 1'b1); idle();
    drain();
    chk("unity_count", out_log.size() - b, 3);
    chk("unity_0", out_log[b], 16'd1234);
    chk("unity_1", out_log[b+1], 16'hFFFB);
    chk("unity_2", out_log[b+2], 16'd0);
    chk("unity_no_ovf", ovf_seen, 0);

    // Rounding at 1.5
    scale_reg = 16'h0180;
    b = out_log.size();
    send(16'd100, 1'b0); send(16'd3, 1'b0); send(16'hFFFD, 1'b1); idle();
    drain();
    chk("round_100", out_log[b], 16'd150);
    chk("round_3", out_log[b+1], 16'd5);
    chk("round_m3", out_log[b+2], 16'hFFFC);

    // Overflow, two single-beat packets
    scale_reg = 16'h7FFF;
    b = out_log.size();
    o0 = ovf_seen;
    send(16'd30000, 1'b1); send(-16'sd30000, 1'b1); idle();
    drain();
`ifdef AXIS_SCALE_SAT_EN
    chk("ovf_pos", out_log[b], 16'h7FFF);
    chk("ovf_neg", out_log[b+1], 16'h8000);
`else
    chk("ovf_pos", out_log[b], 16'h978B);
    chk("ovf_neg", out_log[b+1], 16'h6875);
`endif
    chk("ovf_pulses", ovf_seen - o0, 2);

    // Scale change mid-packet
    scale_reg = 16'h0100;
    b = out_log.size();
    send(16'd200, 1'b0);
    scale_reg = 16'h0200;
    send(16'd200, 1'b0); send(16'd200, 1'b0); send(16'd200, 1'b1);
    for (int i = 0; i < 4; i++) send(16'd200, i == 3);
    idle();
    drain();
    for (int i = 0; i < 4; i++) chk("pkt_a", out_log[b+i], 16'd200);
    for (int i = 4; i < 8; i++) chk("pkt_b", out_log[b+i], 16'd400);

    // Backpressure: 5-cycle stall mid-stream
    strict = 1'b0;
    scale_reg = 16'h0100;
    b = out_log.size();
    fork
      begin
        for (int i = 0; i < 16; i++) send(16'(i * 7 - 50), i == 15);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 m_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();
    chk("bp_count", out_log.size() - b, 16);
    chk("bp_first", out_log[b], 16'hFFCE);
    chk("bp_last", out_log[b+15], 16'd55);

    // Reset with three beats in flight
    strict = 1'b1;
    send(16'd11, 1'b0); send(16'd22, 1'b0); send(16'd33, 1'b0); idle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", m_tvalid, 0);
    chk("rst_mid_busy", busy, 0);
    exp_q.delete();
    tb_in_pkt = 1'b0;
    b = out_log.size();
    o0 = n_out;
    scale_reg = 16'h0300;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'd10, 1'b1); idle();
    drain();
    chk("post_rst_count", n_out - o0, 1);
    chk("post_rst_data", out_log[b], 16'd30);

    chk("beats_in_vs_out", n_out, n_in - 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
